// File: rtl/mpc_qp_admm_vec_axpy.sv
// mpc_qp_admm_vec_axpy: in-place y += alpha*x over the ADMM temp RAM (read port 0, write port 1).
// Define MPC_ADMM_AXPY_SAT_EN to clip results and raise sat_flag; otherwise results wrap.
module mpc_qp_admm_vec_axpy #(
  parameter int DataWidth = 21,
  parameter int AddressWidth = 5,
  parameter int FracBits = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [AddressWidth:0]   len,
  input  logic [AddressWidth-1:0] x_base,
  input  logic [AddressWidth-1:0] y_base,
  input  logic [DataWidth-1:0]    alpha,
  output logic                    busy,
  output logic                    done,
  output logic                    sat_flag,
  output logic [AddressWidth-1:0] address0,
  output logic                    ce0,
  output logic                    we0,
  output logic [DataWidth-1:0]    d0,
  input  logic [DataWidth-1:0]    q0,
  output logic [AddressWidth-1:0] address1,
  output logic                    ce1,
  output logic                    we1,
  output logic [DataWidth-1:0]    d1,
  input  logic [DataWidth-1:0]    q1
);
  localparam int DW = DataWidth;
  localparam int AW = AddressWidth;
  localparam int PW = 2 * DataWidth;
  localparam int SW = 2 * DataWidth - FracBits + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic ph, yv, wv, done_r, accept, last_rd, clip;
  logic [AW:0] cnt, len_r;
  logic [AW-1:0] xb, yb, ya, wa;
  logic signed [DW-1:0] alpha_r, xr, wd, res;
  logic signed [PW-1:0] p, pr;
  logic signed [PW-FracBits-1:0] r;
  logic signed [SW-1:0] s;
  logic unused;
  assign accept = state == IDLE && start;
  assign last_rd = state == RUN && ph && (cnt + (AW+1)'(1)) == len_r;
  always_comb begin
    state_nx = state;
    state_nx = (accept && len != '0) ? RUN :
               last_rd ? DRAIN :
               (state == DRAIN && ph) ? IDLE : state;
  end
  // q0 holds x[i] in the cycle after the x read and y[i] in the cycle after the y read
  assign p = alpha_r * xr;
  assign pr = p + (PW'(1) << (FracBits - 1));
  assign r = pr[PW-1:FracBits];
  assign s = {{(SW-DW){q0[DW-1]}}, q0} + {r[PW-FracBits-1], r};
  assign clip = !(&s[SW-1:DW-1] || !(|s[SW-1:DW-1]));
`ifdef MPC_ADMM_AXPY_SAT_EN
  logic sat_r;
  assign res = clip ? (s[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}) : s[DW-1:0];
  assign sat_flag = sat_r;
  assign unused = ^{pr[FracBits-1:0], q1};
  always_ff @(posedge clk)
    if (reset) sat_r <= 1'b0;
    else sat_r <= accept ? 1'b0 : (yv && clip) ? 1'b1 : sat_r;
`else
  assign res = s[DW-1:0];
  assign sat_flag = 1'b0;
  assign unused = ^{pr[FracBits-1:0], s[SW-1:DW], clip, q1};
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ph <= 1'b0;
      cnt <= '0;
      yv <= 1'b0;
      wv <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state <= state_nx;
      ph <= state != IDLE ? ~ph : 1'b0;
      cnt <= accept ? '0 : (state == RUN && ph) ? cnt + (AW+1)'(1) : cnt;
      yv <= state == RUN && ph;
      wv <= yv;
      done_r <= (accept && len == '0) || (state == DRAIN && ph);
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      len_r <= len;
      xb <= x_base;
      yb <= y_base;
      alpha_r <= alpha;
    end
    if (state == RUN && ph) begin
      xr <= q0;
      ya <= yb + cnt[AW-1:0];
    end
    if (yv) begin
      wa <= ya;
      wd <= res;
    end
  end
  assign busy = state != IDLE;
  assign done = done_r;
  assign ce0 = state == RUN;
  assign we0 = 1'b0;
  assign d0 = '0;
  assign address0 = ce0 ? (ph ? yb : xb) + cnt[AW-1:0] : '0;
  assign ce1 = wv;
  assign we1 = wv;
  assign address1 = wv ? wa : '0;
  assign d1 = wv ? wd : '0;
endmodule

// File: tb/tb_mpc_qp_admm_vec_axpy.sv
// tb_mpc_qp_admm_vec_axpy: scoreboard bench with a behavioural dual-port read-first RAM.
module tb_mpc_qp_admm_vec_axpy;
  logic clk = 0, reset = 1, start = 0;
  logic [5:0] len = 0;
  logic [4:0] x_base = 0, y_base = 0;
  logic [20:0] alpha = 0;
  logic busy, done, sat_flag, ce0, we0, ce1, we1;
  logic [4:0] address0, address1;
  logic [20:0] d0, d1, q0;
  logic [20:0] q1 = '0;
  logic [20:0] mem [32];
  logic tb_we = 0;
  logic [4:0] tb_a = 0;
  logic [20:0] tb_d = 0;
  typedef struct {logic [4:0] a; logic [20:0] d;} wr_t;
  wr_t sb[$];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  mpc_qp_admm_vec_axpy dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .x_base(x_base), .y_base(y_base),
    .alpha(alpha), .busy(busy), .done(done), .sat_flag(sat_flag),
    .address0(address0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0),
    .address1(address1), .ce1(ce1), .we1(we1), .d1(d1), .q1(q1)
  );

  always @(posedge clk) begin
    if (ce0) q0 <= mem[address0];
    if (ce1 && we1) mem[address1] <= d1;
    if (tb_we) mem[tb_a] <= tb_d;
  end

  always @(negedge clk) if (!reset) begin
    if (ce1 && we1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0d data=%0d required none", address1, $signed(d1));
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (address1 !== e.a || d1 !== e.d) begin
          errors++;
          $display("FAIL write got addr=%0d data=%0d required addr=%0d data=%0d",
                   address1, $signed(d1), e.a, $signed(e.d));
        end
      end
    end
    if (ce0 && ce1 && address0 == address1) begin
      errors++;
      $display("FAIL port_clash got addr0=addr1=%0d required distinct", address0);
    end
    if (ce0 && (we0 !== 1'b0 || d0 !== '0)) begin
      errors++;
      $display("FAIL port0_write got we0=%b d0=%0d required 0", we0, d0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic poke(input int a, input int d);
    tb_we = 1;
    tb_a = 5'(a);
    tb_d = 21'(d);
    @(negedge clk);
    tb_we = 0;
  endtask

  // Pushes the expected writes, pulses start, returns in cycle 0.
  task automatic start_op(input int n, input int xa, input int ya, input int a, output bit exp_sat);
    bit clipped;
    clipped = 0;
    for (int i = 0; i < n; i++) begin
      longint xv, yv, r, s;
      logic [63:0] su;
      wr_t e;
      xv = longint'($signed(mem[(xa + i) % 32]));
      yv = longint'($signed(mem[(ya + i) % 32]));
      r = (longint'(a) * xv + 2048) >>> 12;
      s = yv + r;
      su = s;
      if (s > 1048575 || s < -1048576) clipped = 1;
      e.a = 5'((ya + i) % 32);
`ifdef MPC_ADMM_AXPY_SAT_EN
      e.d = s > 1048575 ? 21'h0FFFFF : s < -1048576 ? 21'h100000 : su[20:0];
`else
      e.d = su[20:0];
`endif
      sb.push_back(e);
    end
`ifdef MPC_ADMM_AXPY_SAT_EN
    exp_sat = clipped;
`else
    exp_sat = 0;
`endif
    @(negedge clk);
    start = 1;
    len = 6'(n);
    x_base = 5'(xa);
    y_base = 5'(ya);
    alpha = 21'(a);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, sat_flag, ce0, ce1, we0, we1, address0, address1, d0, d1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b sat=%b ce0=%b ce1=%b a0=%0d a1=%0d d1=%0d required all 0",
               busy, done, sat_flag, ce0, ce1, address0, address1, d1);
    end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit es;
    int k;
    poke(0, 4096); poke(1, 8192); poke(2, -4096);
    poke(8, 100); poke(9, 200); poke(10, 300);
    start_op(3, 0, 8, 2048, es);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b required 1", busy); end
    wait_done(k);
    checks++;
    if (k !== 8) begin errors++; $display("FAIL basic_done_cycle got %0d required 8", k); end
    checks++;
    if (busy !== 1'b0 || sat_flag !== es) begin
      errors++; $display("FAIL basic_busy_sat got busy=%b sat=%b required busy=0 sat=%b", busy, sat_flag, es);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b required 0", done); end
    checks++;
    if (mem[8] !== 21'(2148) || mem[9] !== 21'(4296) || mem[10] !== 21'(-1748)) begin
      errors++;
      $display("FAIL basic_mem got %0d %0d %0d required 2148 4296 -1748",
               $signed(mem[8]), $signed(mem[9]), $signed(mem[10]));
    end
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL basic_pending got %0d required 0", sb.size()); end
  endtask

  task automatic test_alias;
    bit es;
    int k;
    poke(4, 1000); poke(5, -1000);
    start_op(2, 4, 4, 4096, es);
    wait_done(k);
    checks++;
    if (k !== 6) begin errors++; $display("FAIL alias_done_cycle got %0d required 6", k); end
    @(negedge clk);
    checks++;
    if (mem[4] !== 21'(2000) || mem[5] !== 21'(-2000)) begin
      errors++; $display("FAIL alias_mem got %0d %0d required 2000 -2000", $signed(mem[4]), $signed(mem[5]));
    end
  endtask

  task automatic test_sat;
    bit es;
    int k;
    poke(20, 1048000); poke(21, 4096);
    start_op(1, 21, 20, 4096, es);
    wait_done(k);
    checks++;
    if (k !== 4) begin errors++; $display("FAIL sat_done_cycle got %0d required 4", k); end
    @(negedge clk);
`ifdef MPC_ADMM_AXPY_SAT_EN
    checks++;
    if (mem[20] !== 21'(1048575) || sat_flag !== 1'b1) begin
      errors++; $display("FAIL sat_clip got %0d flag=%b required 1048575 flag=1", $signed(mem[20]), sat_flag);
    end
`else
    checks++;
    if (mem[20] !== 21'(-1045056) || sat_flag !== 1'b0) begin
      errors++; $display("FAIL sat_wrap got %0d flag=%b required -1045056 flag=0", $signed(mem[20]), sat_flag);
    end
`endif
    checks++;
    if (sat_flag !== es) begin errors++; $display("FAIL sat_sticky got %b required %b", sat_flag, es); end
  endtask

  task automatic test_round;
    bit es;
    int k;
    poke(12, 1); poke(13, -1); poke(14, 10); poke(15, 10);
    start_op(2, 12, 14, 2048, es);
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL round_sat_clear got %b required 0", sat_flag); end
    wait_done(k);
    @(negedge clk);
    checks++;
    if (mem[14] !== 21'(11) || mem[15] !== 21'(10)) begin
      errors++; $display("FAIL round_mem got %0d %0d required 11 10", $signed(mem[14]), $signed(mem[15]));
    end
  endtask

  task automatic test_len0;
    bit es;
    start_op(0, 0, 8, 4096, es);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ce0 !== 1'b0 || ce1 !== 1'b0) begin
      errors++; $display("FAIL len0_cycle0 got done=%b busy=%b ce0=%b ce1=%b required 1 0 0 0", done, busy, ce0, ce1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || ce0 !== 1'b0 || ce1 !== 1'b0) begin
        errors++; $display("FAIL len0_after got done=%b busy=%b ce0=%b ce1=%b required 0", done, busy, ce0, ce1);
      end
    end
  endtask

  task automatic test_busy_start;
    bit es;
    int ndone, first;
    poke(0, 4096); poke(1, 4096); poke(8, 5); poke(9, -5);
    start_op(2, 0, 8, 4096, es);
    ndone = 0;
    first = -1;
    for (int c = 0; c < 20; c++) begin
      if (c == 1) begin start = 1; len = 6'd5; x_base = 5'd16; y_base = 5'd24; end
      if (c == 2) start = 0;
      if (done === 1'b1) begin ndone++; if (first < 0) first = c; end
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1 || first !== 6) begin
      errors++; $display("FAIL busy_start got dones=%0d at %0d required 1 at 6", ndone, first);
    end
    checks++;
    if (mem[8] !== 21'(4101) || mem[9] !== 21'(4091)) begin
      errors++; $display("FAIL busy_start_mem got %0d %0d required 4101 4091", $signed(mem[8]), $signed(mem[9]));
    end
  endtask

  task automatic test_reset_mid;
    bit es;
    int k, ndone;
    for (int i = 0; i < 4; i++) poke(i, 4096);
    for (int i = 8; i < 12; i++) poke(i, 1);
    start_op(4, 0, 8, 1024, es);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++;
    if ({busy, done, sat_flag, ce0, ce1, we0, we1, address0, address1, d0, d1} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got busy=%b done=%b ce0=%b ce1=%b a0=%0d a1=%0d required all 0",
               busy, done, ce0, ce1, address0, address1);
    end
    reset = 0;
    sb.delete();
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1 || ce1 === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL reset_mid_quiet got %0d required 0", ndone); end
    poke(30, 8192); poke(31, 7);
    start_op(1, 30, 31, -4096, es);
    wait_done(k);
    checks++;
    if (k !== 4) begin errors++; $display("FAIL reset_mid_rerun got %0d required 4", k); end
    @(negedge clk);
    checks++;
    if (mem[31] !== 21'(-8185) || sb.size() !== 0) begin
      errors++; $display("FAIL reset_mid_mem got %0d pending=%0d required -8185 pending=0", $signed(mem[31]), sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_alias;
    test_sat;
    test_round;
    test_len0;
    test_busy_start;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
